// File: rtl/fetch_stage.sv
// Instruction fetch stage: BOOT/FETCH/HOLD sequencer feeding registered instructions to decode.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_2000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [6:0]  last_opcode,
    output logic [2:0]  last_funct3,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [31:0] PCprime,
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state_reg;
    logic [31:0] pc;
    logic [31:0] hold_buf_reg;

    logic        take_redirect;
    logic        load_fetch;
    logic        load_hold;
    logic        load_bubble;
    logic        capture_hold;
    logic [31:0] target_aligned;
    logic [31:0] pc_plus4;

    assign target_aligned = redirect_target & 32'hFFFF_FFFC;
    assign pc_plus4       = pc + 32'd4;

    // Redirect outranks every other FETCH/HOLD event; BOOT ignores it.
    always_comb begin
        take_redirect = redirect && (state_reg != BOOT);
        load_fetch    = (state_reg == FETCH) && !redirect && imem_ready && !stall;
        capture_hold  = (state_reg == FETCH) && !redirect && imem_ready && stall;
        load_hold     = (state_reg == HOLD) && !redirect && !stall;
        load_bubble   = take_redirect || ((state_reg == FETCH) && !imem_ready && !stall);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= BOOT;
            pc           <= RESET_PC;
            hold_buf_reg <= 32'd0;
            inst         <= NOP_INST;
            inst_valid   <= 1'b0;
            PCprime      <= RESET_PC;
        end else begin
            case (state_reg)
                BOOT: state_reg <= FETCH;
                FETCH: begin
                    if (capture_hold) begin
                        hold_buf_reg <= imem_rdata;
                        state_reg    <= HOLD;
                    end
                end
                HOLD: begin
                    if (take_redirect || load_hold) begin
                        state_reg <= FETCH;
                    end
                end
                default: state_reg <= BOOT;
            endcase

            if (take_redirect) begin
                pc <= target_aligned;
            end else if (load_fetch || load_hold) begin
                pc <= pc_plus4;
            end

            if (load_bubble) begin
                inst       <= NOP_INST;
                inst_valid <= 1'b0;
            end else if (load_fetch) begin
                inst       <= imem_rdata;
                inst_valid <= 1'b1;
                PCprime    <= pc;
            end else if (load_hold) begin
                inst       <= hold_buf_reg;
                inst_valid <= 1'b1;
                PCprime    <= pc;
            end
        end
    end

    assign imem_req  = (state_reg == FETCH);
    assign imem_addr = pc;

    // Decode fields always come from the registered word, never the memory bus.
    assign last_opcode = inst[6:0];
    assign last_funct3 = inst[14:12];
    assign rs1         = inst[19:15];
    assign rs2         = inst[24:20];
    assign rd          = inst[11:7];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_reg;
    logic [31:0] bubble_count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count_reg  <= 32'd0;
            bubble_count_reg <= 32'd0;
        end else begin
            if (load_fetch || load_hold) begin
                fetch_count_reg <= fetch_count_reg + 32'd1;
            end
            if (load_bubble) begin
                bubble_count_reg <= bubble_count_reg + 32'd1;
            end
        end
    end

    assign fetch_count  = fetch_count_reg;
    assign bubble_count = bubble_count_reg;
`else
    assign fetch_count  = 32'd0;
    assign bubble_count = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic against a behavioural model.
module tb_fetch_stage;

    localparam logic [31:0] RPC = 32'h0000_2000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] inst;
    logic        inst_valid;
    logic [6:0]  last_opcode;
    logic [2:0]  last_funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] PCprime;
    logic [31:0] fetch_count;
    logic [31:0] bubble_count;

    fetch_stage dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_target(redirect_target),
        .inst(inst), .inst_valid(inst_valid),
        .last_opcode(last_opcode), .last_funct3(last_funct3),
        .rs1(rs1), .rs2(rs2), .rd(rd),
        .PCprime(PCprime),
        .fetch_count(fetch_count), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Behavioural model: "booting", "holding a word", the fetch PC and what decode currently sees.
    bit          m_boot;
    bit          m_hold;
    logic [31:0] m_held;
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    bit          m_valid;
    logic [31:0] m_pcp;
    logic [31:0] m_fetches;
    logic [31:0] m_bubbles;

    function automatic void model_reset();
        m_boot = 1; m_hold = 0; m_held = 0; m_pc = RPC;
        m_inst = NOP; m_valid = 0; m_pcp = RPC; m_fetches = 0; m_bubbles = 0;
    endfunction

    function automatic void model_load(input logic [31:0] w);
        m_inst = w; m_valid = 1; m_pcp = m_pc; m_pc = m_pc + 32'd4; m_fetches = m_fetches + 1;
    endfunction

    function automatic void model_bubble();
        m_inst = NOP; m_valid = 0; m_bubbles = m_bubbles + 1;
    endfunction

    function automatic void model_step(input bit s, input bit r, input logic [31:0] t,
                                       input bit rdy, input logic [31:0] d);
        if (m_boot) begin
            m_boot = 0;
        end else if (m_hold) begin
            if (r) begin
                model_bubble(); m_pc = t & ~32'h3; m_hold = 0;
            end else if (!s) begin
                model_load(m_held); m_hold = 0;
            end
        end else if (r) begin
            model_bubble(); m_pc = t & ~32'h3;
        end else if (rdy && !s) begin
            model_load(d);
        end else if (rdy) begin
            m_held = d; m_hold = 1;
        end else if (!s) begin
            model_bubble();
        end
    endfunction

    function automatic logic [24:0] fields_of(input logic [31:0] w);
        logic [6:0] op; logic [2:0] f3; logic [4:0] a, b, c;
        op = 7'(w % 128);
        f3 = 3'((w / 4096) % 8);
        a  = 5'((w / 32768) % 32);
        b  = 5'((w / 1048576) % 32);
        c  = 5'((w / 128) % 32);
        return {op, f3, a, b, c};
    endfunction

    function automatic logic [31:0] exp_fc();
`ifdef FETCH_PERF_CNT_EN
        return m_fetches;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] exp_bc();
`ifdef FETCH_PERF_CNT_EN
        return m_bubbles;
`else
        return 32'd0;
`endif
    endfunction

    // Drive one cycle of inputs from the negedge, advance the model at the posedge, return at the next negedge.
    task automatic cyc(input bit s, input bit r, input logic [31:0] t, input bit rdy, input logic [31:0] d);
        stall = s; redirect = r; redirect_target = t; imem_ready = rdy; imem_rdata = d;
        @(posedge clk);
        model_step(s, r, t, rdy, d);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1; stall = 0; redirect = 0; imem_ready = 0; imem_rdata = 0; redirect_target = 0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        cyc(0, 0, 0, 1, 32'h1111_1111);
        cyc(0, 0, 0, 1, 32'h2222_2222);
        reset = 1;
        #1;
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        tests++; if (imem_addr !== RPC) begin fails++; $display("FAIL reset_addr: got %h expected %h", imem_addr, RPC); end
        tests++; if (inst !== NOP || inst_valid !== 1'b0) begin fails++; $display("FAIL reset_inst: got %h/%b expected %h/0", inst, inst_valid, NOP); end
        tests++; if (PCprime !== RPC) begin fails++; $display("FAIL reset_pcprime: got %h expected %h", PCprime, RPC); end
        tests++; if (fetch_count !== 0 || bubble_count !== 0) begin fails++; $display("FAIL reset_counters: got %h/%h expected 0/0", fetch_count, bubble_count); end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 0;
        $display("[TB] test_reset done");
    endtask

    task automatic test_sequential();
        logic [31:0] w = 32'h0050_0093;
        apply_reset();
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL boot_req: got %b expected 0", imem_req); end
        cyc(0, 0, 0, 1, w);
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h2000) begin fails++; $display("FAIL seq_addr0: got %b/%h expected 1/00002000", imem_req, imem_addr); end
        cyc(0, 0, 0, 1, w);
        tests++; if (imem_addr !== 32'h2004) begin fails++; $display("FAIL seq_addr1: got %h expected 00002004", imem_addr); end
        tests++; if (PCprime !== 32'h2000 || inst_valid !== 1'b1 || inst !== w) begin fails++; $display("FAIL seq_out: got %h/%b/%h expected 00002000/1/%h", PCprime, inst_valid, inst, w); end
        tests++; if (rd !== 5'd1 || last_opcode !== 7'b0010011) begin fails++; $display("FAIL seq_fields: got rd=%0d op=%b expected rd=1 op=0010011", rd, last_opcode); end
        cyc(0, 0, 0, 1, w);
        tests++; if (imem_addr !== 32'h2008 || PCprime !== 32'h2004) begin fails++; $display("FAIL seq_addr2: got %h/%h expected 00002008/00002004", imem_addr, PCprime); end
        $display("[TB] test_sequential done");
    endtask

    task automatic test_hold();
        logic [31:0] w0 = 32'h0010_0113;
        logic [31:0] w1 = 32'h00A2_8293;
        apply_reset();
        cyc(0, 0, 0, 1, w0);
        cyc(0, 0, 0, 1, w0);
        cyc(1, 0, 0, 1, w1);
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL hold_req: got %b expected 0", imem_req); end
        tests++; if (inst !== w0 || PCprime !== 32'h2000) begin fails++; $display("FAIL hold_frozen: got %h/%h expected %h/00002000", inst, PCprime, w0); end
        cyc(1, 0, 0, 1, 32'hDEAD_BEEF);
        tests++; if (imem_req !== 1'b0 || inst !== w0) begin fails++; $display("FAIL hold_frozen2: got %b/%h expected 0/%h", imem_req, inst, w0); end
        cyc(0, 0, 0, 1, 32'hDEAD_BEEF);
        tests++; if (inst !== w1 || PCprime !== 32'h2004 || inst_valid !== 1'b1) begin fails++; $display("FAIL hold_release: got %h/%h/%b expected %h/00002004/1", inst, PCprime, inst_valid, w1); end
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h2008) begin fails++; $display("FAIL hold_next: got %b/%h expected 1/00002008", imem_req, imem_addr); end
        $display("[TB] test_hold done");
    endtask

    task automatic test_redirect();
        apply_reset();
        cyc(0, 0, 0, 1, 32'h0040_0193);
        cyc(0, 0, 0, 1, 32'h0040_0193);
        cyc(1, 1, 32'h0000_3002, 1, 32'h1234_5678);
        tests++; if (inst !== NOP || inst_valid !== 1'b0) begin fails++; $display("FAIL redir_bubble: got %h/%b expected %h/0", inst, inst_valid, NOP); end
        tests++; if (imem_addr !== 32'h3000 || PCprime !== 32'h2000) begin fails++; $display("FAIL redir_addr: got %h/%h expected 00003000/00002000", imem_addr, PCprime); end
        $display("[TB] test_redirect done");
    endtask

    task automatic test_bubbles();
        apply_reset();
        cyc(0, 0, 0, 1, 32'h0000_0013);
        cyc(0, 0, 0, 1, 32'h0030_0213);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 32'hFFFF_FFFF);
            tests++; if (imem_addr !== 32'h2004 || inst_valid !== 1'b0 || inst !== NOP) begin fails++; $display("FAIL bubble_%0d: got %h/%b/%h expected 00002004/0/%h", i, imem_addr, inst_valid, inst, NOP); end
        end
`ifdef FETCH_PERF_CNT_EN
        tests++; if (bubble_count !== 32'd3 || fetch_count !== 32'd1) begin fails++; $display("FAIL bubble_count: got %0d/%0d expected 3/1", bubble_count, fetch_count); end
`else
        tests++; if (bubble_count !== 32'd0 || fetch_count !== 32'd0) begin fails++; $display("FAIL bubble_count: got %0d/%0d expected 0/0", bubble_count, fetch_count); end
`endif
        $display("[TB] test_bubbles done");
    endtask

    task automatic test_wrap();
        apply_reset();
        cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 32'hFFFF_FFFE, 1, 0);
        tests++; if (imem_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_target: got %h expected fffffffc", imem_addr); end
        cyc(0, 0, 0, 1, 32'h0070_0393);
        tests++; if (imem_addr !== 32'h0 || PCprime !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_next: got %h/%h expected 00000000/fffffffc", imem_addr, PCprime); end
        $display("[TB] test_wrap done");
    endtask

    task automatic test_reset_in_hold();
        apply_reset();
        cyc(0, 0, 0, 1, 32'h0010_0093);
        cyc(0, 0, 0, 1, 32'h0010_0093);
        cyc(1, 0, 0, 1, 32'h0020_0093);
        reset = 1;
        #1;
        tests++; if (imem_req !== 1'b0 || imem_addr !== RPC || inst !== NOP || inst_valid !== 1'b0 || PCprime !== RPC) begin fails++; $display("FAIL hold_reset: got %b/%h/%h/%b/%h expected 0/%h/%h/0/%h", imem_req, imem_addr, inst, inst_valid, PCprime, RPC, NOP, RPC); end
        tests++; if (fetch_count !== 0 || bubble_count !== 0) begin fails++; $display("FAIL hold_reset_cnt: got %h/%h expected 0/0", fetch_count, bubble_count); end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 0; stall = 0;
        cyc(0, 0, 0, 0, 0);
        tests++; if (imem_req !== 1'b1 || imem_addr !== RPC) begin fails++; $display("FAIL hold_reset_resume: got %b/%h expected 1/%h", imem_req, imem_addr, RPC); end
        $display("[TB] test_reset_in_hold done");
    endtask

    task automatic test_random();
        bit s, r, rdy;
        logic [31:0] t, d;
        int f0 = fails;
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            s   = ($urandom_range(0, 9) < 3);
            r   = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            t   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
            d   = $urandom;
            cyc(s, r, t, rdy, d);
            tests++; if (imem_req !== (!m_boot && !m_hold) || imem_addr !== m_pc) begin fails++; $display("FAIL rnd_req[%0d]: got %b/%h expected %b/%h", n, imem_req, imem_addr, !m_boot && !m_hold, m_pc); end
            tests++; if (inst !== m_inst || inst_valid !== m_valid || PCprime !== m_pcp) begin fails++; $display("FAIL rnd_out[%0d]: got %h/%b/%h expected %h/%b/%h", n, inst, inst_valid, PCprime, m_inst, m_valid, m_pcp); end
            tests++; if ({last_opcode, last_funct3, rs1, rs2, rd} !== fields_of(m_inst)) begin fails++; $display("FAIL rnd_fields[%0d]: got %h expected %h", n, {last_opcode, last_funct3, rs1, rs2, rd}, fields_of(m_inst)); end
            tests++; if (fetch_count !== exp_fc() || bubble_count !== exp_bc()) begin fails++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d expected %0d/%0d", n, fetch_count, bubble_count, exp_fc(), exp_bc()); end
        end
        $display("[TB] test_random done, %0d new failures", fails - f0);
    endtask

    initial begin
        reset = 1; stall = 0; redirect = 0; imem_ready = 0; imem_rdata = 0; redirect_target = 0;
        model_reset();
        test_reset();
        test_sequential();
        test_hold();
        test_redirect();
        test_bubbles();
        test_wrap();
        test_reset_in_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
